// File: rtl/spi_byte_master.sv
`default_nettype none
// ============================================================================
// spi_byte_master : SPI mode-0 byte master with CSB hold/release and guard gap
// Revision 1.0
// ============================================================================
module spi_byte_master #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  input  logic                  tx_hold,
  output logic                  tx_ready,
  // "release" is a reserved word, hence the longer name
  input  logic                  release_hold,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  spi_csb,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  output logic                  spi_sdoenb,
  input  logic                  spi_miso
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GUARD = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [PRESCALE_W-1:0] cnt, cnt_nxt;
  logic [PRESCALE_W-1:0] presc, presc_nxt;
  logic [3:0]            edge_cnt, edge_cnt_nxt;
  logic                  hold, hold_nxt;
  logic [6:0]            tx_sh, tx_sh_nxt;
  logic [7:0]            rx_sh, rx_sh_nxt;
  logic [7:0]            rx_data_nxt;
  logic                  rx_valid_nxt;
  logic                  csb_nxt, sck_nxt, mosi_nxt, sdoenb_nxt;
  logic                  accept;

  assign tx_ready = !wb_rst_i && (state == IDLE || state == HOLD);
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    presc_nxt    = presc;
    edge_cnt_nxt = edge_cnt;
    hold_nxt     = hold;
    tx_sh_nxt    = tx_sh;
    rx_sh_nxt    = rx_sh;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    csb_nxt      = spi_csb;
    sck_nxt      = spi_sck;
    mosi_nxt     = spi_mosi;
    sdoenb_nxt   = spi_sdoenb;
    case (state)
      IDLE, HOLD: begin
        // An accepted byte takes priority over a coincident release
        if (accept) begin
          state_nxt    = SHIFT;
          presc_nxt    = prescale;
          cnt_nxt      = prescale;
          hold_nxt     = tx_hold;
          edge_cnt_nxt = 4'd0;
          tx_sh_nxt    = tx_data[6:0];
          mosi_nxt     = tx_data[7];
          csb_nxt      = 1'b0;
          sdoenb_nxt   = 1'b0;
          sck_nxt      = 1'b0;
        end else if (state == HOLD && release_hold) begin
          state_nxt  = GUARD;
          cnt_nxt    = presc;
          csb_nxt    = 1'b1;
          sdoenb_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - PRESCALE_W'(1);
        end else begin
          cnt_nxt      = presc;
          edge_cnt_nxt = edge_cnt + 4'd1;
          if (!edge_cnt[0]) begin
            sck_nxt   = 1'b1;
            rx_sh_nxt = {rx_sh[6:0], spi_miso};
          end else begin
            sck_nxt = 1'b0;
            if (edge_cnt != 4'd15) begin
              mosi_nxt  = tx_sh[6];
              tx_sh_nxt = {tx_sh[5:0], 1'b0};
            end else begin
              rx_valid_nxt = 1'b1;
              rx_data_nxt  = rx_sh;
              if (hold) begin
                state_nxt = HOLD;
              end else begin
                state_nxt  = GUARD;
                csb_nxt    = 1'b1;
                sdoenb_nxt = 1'b1;
              end
            end
          end
        end
      end
      GUARD: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - PRESCALE_W'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      presc      <= '0;
      edge_cnt   <= 4'd0;
      hold       <= 1'b0;
      tx_sh      <= 7'd0;
      rx_sh      <= 8'd0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      spi_csb    <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_sdoenb <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      presc      <= presc_nxt;
      edge_cnt   <= edge_cnt_nxt;
      hold       <= hold_nxt;
      tx_sh      <= tx_sh_nxt;
      rx_sh      <= rx_sh_nxt;
      rx_data    <= rx_data_nxt;
      rx_valid   <= rx_valid_nxt;
      spi_csb    <= csb_nxt;
      spi_sck    <= sck_nxt;
      spi_mosi   <= mosi_nxt;
      spi_sdoenb <= sdoenb_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_master.sv
`default_nettype none
// tb_spi_byte_master : directed and randomized checks of spi_byte_master against
// a cycle-arithmetic waveform reference and a bit-stream SPI slave / flash image.
module tb_spi_byte_master;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] prescale = '0;
  logic [7:0]    tx_data = 8'd0;
  logic          tx_valid = 1'b0;
  logic          tx_hold = 1'b0;
  logic          release_hold = 1'b0;
  logic          tx_ready, rx_valid, busy;
  logic          spi_csb, spi_sck, spi_mosi, spi_sdoenb, spi_miso;
  logic [7:0]    rx_data;
  logic          loopback = 1'b1;
  logic          slave_miso = 1'b0;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int csb_rises = 0;
  bit sl_mem [0:1023];
  int sl_wr = 0;
  int sl_rd = 0;
  bit mo_mem [0:1023];
  int mo_cnt = 0;
  logic [7:0] flash_mem [0:1];

  int          r0, c0, mo0, n, endm;
  logic [7:0]  bd [0:2];
  logic [7:0]  bs [0:2];
  int          bp [0:2];
  logic [47:0] cap;

  always #5 clk = ~clk;
  assign spi_miso = loopback ? spi_mosi : slave_miso;

  spi_byte_master #(.PRESCALE_W(PW)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .prescale    (prescale),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_hold     (tx_hold),
    .tx_ready    (tx_ready),
    .release_hold(release_hold),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .spi_csb     (spi_csb),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_sdoenb  (spi_sdoenb),
    .spi_miso    (spi_miso)
  );

  // Mode-0 slave: presents a bit when selected and after every falling SCK
  always @(negedge spi_csb or negedge spi_sck)
    if (spi_csb === 1'b0) begin
      slave_miso = sl_mem[sl_rd % 1024];
      sl_rd++;
    end

  always @(posedge spi_sck) begin
    rises++;
    if (spi_csb === 1'b0) begin
      mo_mem[mo_cnt % 1024] = spi_mosi;
      mo_cnt++;
    end
  end

  always @(posedge spi_csb) csb_rises++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sl_mem[sl_wr % 1024] = b[i];
      sl_wr++;
    end
  endtask

  // Called at the sample point of cycle 0; returns at the sample point of cycle 1+16H
  task automatic send_byte(input logic [7:0] d, input logic hld, input int psc,
                           input logic [7:0] exp_rx, input logic rel, input logic noisy);
    int h;
    int rs;
    h = psc + 1;
    check("ready_at_accept", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data = d;
    tx_hold = hld;
    prescale = PW'(psc);
    release_hold = rel;
    rs = rises;
    tick();
    for (int t = 1; t <= 16 * h; t++) begin
      check("sck_wave", 32'(spi_sck), 32'(((t - 1) / h) % 2));
      check("mosi_bit", 32'(spi_mosi), 32'(d[7 - ((t - 1) / (2 * h))]));
      check("csb_low_shift", 32'(spi_csb), 32'd0);
      check("sdoenb_low_shift", 32'(spi_sdoenb), 32'd0);
      check("no_rx_valid_shift", 32'(rx_valid), 32'd0);
      check("not_ready_shift", 32'(tx_ready), 32'd0);
      check("busy_shift", 32'(busy), 32'd1);
      if (noisy) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data = 8'($urandom);
        tx_hold = 1'($urandom_range(0, 1));
        prescale = PW'($urandom);
        release_hold = 1'($urandom_range(0, 1));
      end else begin
        tx_valid = 1'b0;
        release_hold = 1'b0;
      end
      tick();
    end
    tx_valid = 1'b0;
    release_hold = 1'b0;
    check("rx_valid_strobe", 32'(rx_valid), 32'd1);
    check("rx_data", 32'(rx_data), 32'(exp_rx));
    check("csb_end", 32'(spi_csb), 32'(!hld));
    check("sdoenb_end", 32'(spi_sdoenb), 32'(!hld));
    check("ready_end", 32'(tx_ready), 32'(hld));
    check("busy_end", 32'(busy), 32'd1);
    check("sck_low_end", 32'(spi_sck), 32'd0);
    check("rise_count", 32'(rises - rs), 32'd8);
  endtask

  // Called at the first guard cycle
  task automatic guard_check(input int h, input logic [7:0] rxd);
    for (int i = 1; i < h; i++) begin
      tick();
      check("guard_busy", 32'(busy), 32'd1);
      check("guard_not_ready", 32'(tx_ready), 32'd0);
      check("guard_csb", 32'(spi_csb), 32'd1);
      check("guard_no_strobe", 32'(rx_valid), 32'd0);
      check("guard_rx_stable", 32'(rx_data), 32'(rxd));
    end
    tick();
    check("idle_ready", 32'(tx_ready), 32'd1);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("idle_csb", 32'(spi_csb), 32'd1);
    check("idle_no_strobe", 32'(rx_valid), 32'd0);
    check("idle_rx_stable", 32'(rx_data), 32'(rxd));
  endtask

  task automatic release_from_hold(input int h, input logic [7:0] rxd);
    release_hold = 1'b1;
    tick();
    release_hold = 1'b0;
    check("release_csb", 32'(spi_csb), 32'd1);
    check("release_sdoenb", 32'(spi_sdoenb), 32'd1);
    check("release_busy", 32'(busy), 32'd1);
    check("release_not_ready", 32'(tx_ready), 32'd0);
    check("release_no_strobe", 32'(rx_valid), 32'd0);
    guard_check(h, rxd);
  endtask

  initial begin
    flash_mem[0] = 8'h93;
    flash_mem[1] = 8'h01;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst_csb", 32'(spi_csb), 32'd1);
    check("rst_sdoenb", 32'(spi_sdoenb), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(tx_ready), 32'd1);

    // Loopback, fastest SCK
    loopback = 1'b1;
    send_byte(8'hA5, 1'b0, 0, 8'hA5, 1'b0, 1'b0);
    guard_check(1, 8'hA5);

    // Loopback, prescale 3, input noise during the shift
    send_byte(8'h3C, 1'b0, 3, 8'h3C, 1'b0, 1'b1);
    guard_check(4, 8'h3C);

    // Maximum prescale
    send_byte(8'h5A, 1'b0, (1 << PW) - 1, 8'h5A, 1'b0, 1'b0);
    guard_check(1 << PW, 8'h5A);

    // Flash read: command 0x03, address 0, then two data bytes under one CSB
    loopback = 1'b0;
    sl_wr = sl_rd;
    for (int i = 0; i < 4; i++) push_byte(8'h00);
    push_byte(flash_mem[0]);
    push_byte(flash_mem[1]);
    c0 = csb_rises;
    mo0 = mo_cnt;
    send_byte(8'h03, 1'b1, 1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1, 1, 8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b1, 1, flash_mem[0], 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1, flash_mem[1], 1'b0, 1'b0);
    check("flash_csb_no_rise", 32'(csb_rises - c0), 32'd0);
    cap = '0;
    for (int i = 0; i < 48; i++) cap = {cap[46:0], mo_mem[(mo0 + i) % 1024]};
    check("flash_cmd_addr_hi", 32'(cap[47:24]), 32'h030000);
    check("flash_cmd_addr_lo", 32'(cap[23:0]), 32'h000000);
    release_from_hold(2, flash_mem[1]);
    check("flash_csb_one_rise", 32'(csb_rises - c0), 32'd1);

    // Reset after the third rising SCK edge
    loopback = 1'b1;
    check("abort_ready", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data = 8'hC3;
    tx_hold = 1'b0;
    prescale = PW'(1);
    r0 = rises;
    tick();
    tx_valid = 1'b0;
    repeat (10) tick();
    check("abort_three_rises", 32'(rises - r0), 32'd3);
    check("abort_sck_high", 32'(spi_sck), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_csb", 32'(spi_csb), 32'd1);
    check("abort_sck", 32'(spi_sck), 32'd0);
    check("abort_mosi", 32'(spi_mosi), 32'd0);
    check("abort_no_strobe", 32'(rx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready_low", 32'(tx_ready), 32'd0);
    tick();
    check("abort_ready_in_rst", 32'(tx_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("abort_ready_after", 32'(tx_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("abort_quiet", 32'(rx_valid), 32'd0);
      tick();
    end

    // Reset while in HOLD
    send_byte(8'h66, 1'b1, 0, 8'h66, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("holdrst_csb", 32'(spi_csb), 32'd1);
    check("holdrst_busy", 32'(busy), 32'd0);
    check("holdrst_ready", 32'(tx_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("holdrst_ready_after", 32'(tx_ready), 32'd1);

    // Random bursts against the slave bit stream
    loopback = 1'b0;
    for (int b = 0; b < 12; b++) begin
      n = $urandom_range(1, 3);
      endm = $urandom_range(0, 1);
      sl_wr = sl_rd;
      for (int i = 0; i < n; i++) begin
        bd[i] = 8'($urandom);
        bs[i] = 8'($urandom);
        bp[i] = $urandom_range(0, 3);
        push_byte(bs[i]);
      end
      for (int i = 0; i < n; i++)
        send_byte(bd[i], (i < n - 1) ? 1'b1 : 1'(endm), bp[i], bs[i],
                  1'($urandom_range(0, 1)), 1'b1);
      if (endm == 1) begin
        repeat ($urandom_range(0, 3)) begin
          tick();
          check("hold_csb", 32'(spi_csb), 32'd0);
          check("hold_ready", 32'(tx_ready), 32'd1);
          check("hold_busy", 32'(busy), 32'd1);
          check("hold_no_strobe", 32'(rx_valid), 32'd0);
        end
        release_from_hold(bp[n - 1] + 1, bs[n - 1]);
      end else begin
        guard_check(bp[n - 1] + 1, bs[n - 1]);
      end
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("idle_wait_ready", 32'(tx_ready), 32'd1);
        check("idle_wait_busy", 32'(busy), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_byte_master.md
SPI_BYTE_MASTER -- requirements
Module: spi_byte_master

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 8, width of prescale input.
REQ-002 SHALL have port wb_clk_i  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port prescale  input  PRESCALE_W  SCK half-period = prescale+1 clocks.
REQ-005 SHALL have port tx_data  input  8  byte to shift out, MSB first.
REQ-006 SHALL have port tx_valid  input  1  tx_data offered.
REQ-007 SHALL have port tx_hold  input  1  keep CSB low after this byte.
REQ-008 SHALL have port tx_ready  output  1  byte acceptable this cycle.
REQ-009 SHALL have port release  input  1  pulse: end held transaction.
REQ-010 SHALL have port rx_data  output  8  byte shifted in.
REQ-011 SHALL have port rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-012 SHALL have port busy  output  1  CSB low or guard interval running.
REQ-013 SHALL have ports spi_csb, spi_sck, spi_mosi, spi_sdoenb  output  1 each; spi_miso  input  1.

Function
REQ-014 SHALL operate SPI mode 0 only: SCK idles low, MOSI changes on falling edge, MISO sampled on rising edge.
REQ-015 SHALL implement states IDLE, SHIFT, HOLD, GUARD.
REQ-016 SHALL accept a byte when tx_valid && tx_ready (cycle 0); tx_ready high only in IDLE and HOLD.
REQ-017 SHALL latch tx_data, tx_hold, prescale at acceptance; later changes have no effect on that byte.
REQ-018 SHALL, in cycle 1 after acceptance, drive spi_csb=0, spi_sdoenb=0, spi_mosi=tx_data[7], spi_sck=0.
REQ-019 SHALL, with H=prescale+1, raise SCK at cycle 1+(2k+1)H and lower it at cycle 1+(2k+2)H for bit k=0..7.
REQ-020 SHALL sample spi_miso into the shift register at each rising SCK edge; MOSI advances to the next bit on each falling edge except the 8th.
REQ-021 SHALL pulse rx_valid for exactly one cycle at cycle 1+16H with rx_data = the 8 sampled bits, first sampled in bit 7.
REQ-022 SHALL, if tx_hold=0, drive spi_csb=1 and spi_sdoenb=1 in the rx_valid cycle, enter GUARD for H cycles, then IDLE.
REQ-023 SHALL, if tx_hold=1, keep spi_csb=0 and enter HOLD with tx_ready=1 in the rx_valid cycle; the next byte may be accepted in that same cycle.
REQ-024 SHALL, in HOLD, on release=1 with no accepted byte, raise spi_csb next cycle and enter GUARD; when release and an accepted byte coincide, the byte wins and release is ignored.
REQ-025 SHALL ignore release outside HOLD and ignore tx_valid while tx_ready=0.
REQ-026 SHALL hold rx_data stable between rx_valid strobes.
REQ-027 SHALL assert busy in SHIFT, HOLD, GUARD; deassert only in IDLE.
REQ-028 SHALL treat prescale=0 as H=1 (SCK = clk/2); maximum prescale gives H=2^PRESCALE_W.

Reset
REQ-029 SHALL, while wb_rst_i=1, force state IDLE, spi_csb=1, spi_sdoenb=1, spi_sck=0, spi_mosi=0, rx_data=0, rx_valid=0, busy=0, tx_ready=0.
REQ-030 SHALL, on reset asserted mid-byte or in HOLD, abort with no rx_valid strobe; outputs take reset values in the next cycle.
REQ-031 SHALL raise tx_ready in the first cycle after wb_rst_i deasserts.

Verification
REQ-032 Loopback MOSI->MISO, prescale=0, send 0xA5 hold=0 -> rx_valid at cycle 17 with rx_data=0xA5; CSB high at cycle 17; tx_ready high at cycle 18.
REQ-033 prescale=3, send 0x3C -> SCK period 8 clocks, 8 rising edges, rx_valid at cycle 65, rx_data=0x3C.
REQ-034 Bench spiflash model on spi_* pins, send 0x03,0x00,0x00,0x00 hold=1 then two 0x00 bytes hold=1, then release -> CSB low continuously for all six bytes, last two rx_data equal flash words 0 and 1 (e.g. 0x93, 0x01), CSB high one cycle after release.
REQ-035 tx_valid held high with changing tx_data during SHIFT -> only the accepted byte appears on MOSI; no extra acceptance until tx_ready.
REQ-036 Assert wb_rst_i after the 3rd rising SCK edge -> no rx_valid, CSB=1 and SCK=0 next cycle, tx_ready=1 the cycle after reset release.
REQ-037 In HOLD, assert release and tx_valid in the same cycle -> byte accepted, CSB stays low, release ignored.
